// File: rtl/pixel_loader.sv
// pixel_loader: packs an RGB byte stream into 24-bit pixels and writes them
// to the source pixel RAM at consecutive addresses, flagging frame completion.
module pixel_loader #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned PIXEL_COUNT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [23:0]          mem_di,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   pixel_count
);

  localparam int unsigned CNT_BITS = ADDR_BITS + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(PIXEL_COUNT - 1);

  logic [1:0]           state, state_next;
  logic [1:0]           byte_idx, byte_idx_next;
  logic [7:0]           r_reg, r_next;
  logic [7:0]           g_reg, g_next;
  logic [ADDR_BITS-1:0] pix_idx, pix_next;
  logic                 we_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic [23:0]          di_next;
  logic                 busy_next;
  logic                 done_next;
  logic [CNT_BITS-1:0]  count_next;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    r_next        = r_reg;
    g_next        = g_reg;
    pix_next      = pix_idx;
    we_next       = 1'b0;
    addr_next     = mem_addr;
    di_next       = mem_di;
    busy_next     = busy;
    done_next     = done;
    count_next    = pixel_count;

    case (state)
      ST_IDLE, ST_DONE: begin
        // Bytes arriving outside a load (even alongside start) are dropped.
        if (start) begin
          state_next    = ST_LOAD;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          pix_next      = '0;
          byte_idx_next = 2'd0;
          count_next    = '0;
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          case (byte_idx)
            2'd0: begin
              r_next        = rx_data;
              byte_idx_next = 2'd1;
            end
            2'd1: begin
              g_next        = rx_data;
              byte_idx_next = 2'd2;
            end
            2'd2: begin
              di_next       = {r_reg, g_reg, rx_data};
              addr_next     = pix_idx;
              we_next       = 1'b1;
              byte_idx_next = 2'd0;
              pix_next      = pix_idx + ADDR_BITS'(1);
              count_next    = pixel_count + CNT_BITS'(1);
              if (pix_idx == LAST_IDX) begin
                state_next = ST_DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
              end
            end
            default: byte_idx_next = 2'd0;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_idx    <= 2'd0;
      r_reg       <= 8'd0;
      g_reg       <= 8'd0;
      pix_idx     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_di      <= 24'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pixel_count <= '0;
    end else begin
      state       <= state_next;
      byte_idx    <= byte_idx_next;
      r_reg       <= r_next;
      g_reg       <= g_next;
      pix_idx     <= pix_next;
      mem_we      <= we_next;
      mem_addr    <= addr_next;
      mem_di      <= di_next;
      busy        <= busy_next;
      done        <= done_next;
      pixel_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: directed checks of pixel_loader with a 3-pixel frame
// instance and a full-address-range instance (ADDR_BITS=2, PIXEL_COUNT=4).
module tb_pixel_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;

  logic        mem_we_a, busy_a, done_a;
  logic [9:0]  mem_addr_a;
  logic [23:0] mem_di_a;
  logic [10:0] pixel_count_a;

  logic        mem_we_b, busy_b, done_b;
  logic [1:0]  mem_addr_b;
  logic [23:0] mem_di_b;
  logic [2:0]  pixel_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pixel_loader #(.ADDR_BITS(10), .PIXEL_COUNT(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rx_data(rx_data),
    .rx_valid(rx_valid), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_di(mem_di_a), .busy(busy_a), .done(done_a),
    .pixel_count(pixel_count_a)
  );

  pixel_loader #(.ADDR_BITS(2), .PIXEL_COUNT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rx_data(rx_data),
    .rx_valid(rx_valid), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_di(mem_di_b), .busy(busy_b), .done(done_b),
    .pixel_count(pixel_count_b)
  );

  // One clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic we, input logic [9:0] addr,
                       input logic [23:0] di, input logic bsy, input logic dn,
                       input logic [10:0] pc);
    chk({tag, ".we"},   32'(mem_we_a),      32'(we));
    chk({tag, ".addr"}, 32'(mem_addr_a),    32'(addr));
    chk({tag, ".di"},   32'(mem_di_a),      32'(di));
    chk({tag, ".busy"}, 32'(busy_a),        32'(bsy));
    chk({tag, ".done"}, 32'(done_a),        32'(dn));
    chk({tag, ".pc"},   32'(pixel_count_a), 32'(pc));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic [23:0] px_b [4];
  logic [7:0]  bt;

  initial begin
    px_b[0] = 24'hA1A2A3;
    px_b[1] = 24'hB1B2B3;
    px_b[2] = 24'hC1C2C3;
    px_b[3] = 24'hD1D2D3;

    // Reset state of both instances
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk_a("rst_a", 1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 11'd0);
    chk("rst_b.we",   32'(mem_we_b), 32'd0);
    chk("rst_b.busy", 32'(busy_b), 32'd0);
    chk("rst_b.done", 32'(done_b), 32'd0);
    chk("rst_b.pc",   32'(pixel_count_b), 32'd0);

    // rx_valid in IDLE, and together with start, is ignored
    send_byte(8'h55);
    chk_a("idle_byte", 1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 11'd0);
    start_a  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    start_a  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    chk_a("start", 1'b0, 10'd0, 24'd0, 1'b1, 1'b0, 11'd0);

    // Basic frame, one byte every 4th cycle
    send_byte(8'h01); idle(3);
    send_byte(8'h02); idle(3);
    send_byte(8'h03);
    chk_a("basic_p0", 1'b1, 10'd0, 24'h010203, 1'b1, 1'b0, 11'd1);
    tick();
    chk("basic_p0_we_drop", 32'(mem_we_a), 32'd0);
    idle(2);
    send_byte(8'h0A);
    start_a = 1'b1;   // start during LOAD must not restart the frame
    tick();
    start_a = 1'b0;
    idle(2);
    send_byte(8'h0B); idle(3);
    send_byte(8'h0C);
    chk_a("basic_p1", 1'b1, 10'd1, 24'h0A0B0C, 1'b1, 1'b0, 11'd2);
    idle(3);
    send_byte(8'hFF); idle(3);
    send_byte(8'h80); idle(3);
    send_byte(8'h00);
    chk_a("basic_p2", 1'b1, 10'd2, 24'hFF8000, 1'b0, 1'b1, 11'd3);
    tick();
    chk_a("basic_after", 1'b0, 10'd2, 24'hFF8000, 1'b0, 1'b1, 11'd3);

    // Bytes in DONE are ignored
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk_a("done_ignore", 1'b0, 10'd2, 24'hFF8000, 1'b0, 1'b1, 11'd3);

    // Restart from DONE, then nine back-to-back bytes
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk_a("restart", 1'b0, 10'd2, 24'hFF8000, 1'b1, 1'b0, 11'd0);
    send_byte(8'h01); chk("b2b_1.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h02); chk("b2b_2.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h03);
    chk_a("b2b_p0", 1'b1, 10'd0, 24'h010203, 1'b1, 1'b0, 11'd1);
    send_byte(8'h0A); chk("b2b_4.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h0B); chk("b2b_5.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h0C);
    chk_a("b2b_p1", 1'b1, 10'd1, 24'h0A0B0C, 1'b1, 1'b0, 11'd2);
    send_byte(8'hFF); chk("b2b_7.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h80); chk("b2b_8.we", 32'(mem_we_a), 32'd0);
    send_byte(8'h00);
    chk_a("b2b_p2", 1'b1, 10'd2, 24'hFF8000, 1'b0, 1'b1, 11'd3);
    tick();
    chk("b2b_after.we", 32'(mem_we_a), 32'd0);

    // Reset mid-pixel discards the partial pixel
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_a("mid_rst", 1'b0, 10'd0, 24'd0, 1'b0, 1'b0, 11'd0);
    // Reset wins over start in the same cycle
    reset   = 1'b1;
    start_a = 1'b1;
    tick();
    reset   = 1'b0;
    chk("rst_prio.busy", 32'(busy_a), 32'd0);
    tick();
    start_a = 1'b0;
    chk("rst_start.busy", 32'(busy_a), 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    chk_a("after_rst", 1'b1, 10'd0, 24'h334455, 1'b1, 1'b0, 11'd1);

    // Full address range on the 2-bit instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("full_start.busy", 32'(busy_b), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bt = px_b[i][23:16];
      send_byte(bt);
      chk($sformatf("full_p%0d_b0.we", i), 32'(mem_we_b), 32'd0);
      bt = px_b[i][15:8];
      send_byte(bt);
      chk($sformatf("full_p%0d_b1.we", i), 32'(mem_we_b), 32'd0);
      bt = px_b[i][7:0];
      send_byte(bt);
      chk($sformatf("full_p%0d.we", i),   32'(mem_we_b), 32'd1);
      chk($sformatf("full_p%0d.addr", i), 32'(mem_addr_b), 32'(i));
      chk($sformatf("full_p%0d.di", i),   32'(mem_di_b), 32'(px_b[i]));
      chk($sformatf("full_p%0d.pc", i),   32'(pixel_count_b), 32'(i + 1));
      chk($sformatf("full_p%0d.done", i), 32'(done_b), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("full_pc_100", 32'(pixel_count_b), 32'd4);
    chk("full_busy", 32'(busy_b), 32'd0);
    send_byte(8'hEE); chk("full_post0.we", 32'(mem_we_b), 32'd0);
    send_byte(8'hEE); chk("full_post1.we", 32'(mem_we_b), 32'd0);
    send_byte(8'hEE); chk("full_post2.we", 32'(mem_we_b), 32'd0);
    chk("full_post.addr", 32'(mem_addr_b), 32'd3);
    chk("full_post.done", 32'(done_b), 32'd1);
    chk("full_post.pc", 32'(pixel_count_b), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
